decode_queue_unit: RTL and testbench
====================================

// Module: decode_queue_unit
// PURPOSE
// - Decode stage for the serial 16-bit CPU: takes instruction words from fetch (valid/ready), decodes into a dec_sig_t bundle.
// - Assembles double-word instructions (I_TYPE, M_TYPE), which are an instruction word plus a trailing immediate word.
// - Buffers decoded entries in a DEPTH-deep FIFO ahead of execute (valid/ready); supports flush and halt on SYS_END.
// PARAMETERS
// - WORD_W  16  fetch word width, >=16; decode uses bits [15:0], imm captures all WORD_W bits
// - DEPTH   4   decoded-entry FIFO depth, >=2 (power of two not required)
// PORTS
// - clock       in   1                  rising-edge clock
// - reset_n     in   1                  synchronous active-low reset
// - flush       in   1                  drop all queued/partial state (jump/branch redirect)
// - in_word     in   WORD_W             fetched instruction or immediate word
// - in_valid    in   1                  in_word valid
// - in_ready    out  1                  decoder accepts in_word this cycle
// - out_sig     out  dec_sig_t          head-of-queue decoded bundle
// - out_imm     out  WORD_W             head immediate word (0 for single-word instrs)
// - out_valid   out  1                  queue non-empty
// - out_ready   in   1                  execute consumes head
// - halted      out  1                  SYS_END decoded; input closed
// - count       out  $clog2(DEPTH+1)    occupied entries
// BEHAVIOUR
// - Reset (reset_n=0 at edge): FSM=FIRST, queue empty, count=0, out_valid=0, halted=0, out_sig='0, out_imm='0.
// - Decode rules: opcode=w[2:0]; bundle zeroed, then fields set per opcode.
//   - R_TYPE: rs1=w[5:3], rs2=w[8:6], rd=w[11:9], alu_op=w[15:12], rfWrite=1.
//   - I_TYPE: rs1, rd, alu_op as R_TYPE; useImm=1, is_double_word=1, rfWrite=1.
//   - B_TYPE: rs1, rs2; offset=w[12:9]; b_type=w[15:13]; alu_op=ADD.
//   - J_TYPE: addr_offset={w[15:12],w[8:4]}; jump_type=w[6]; rd=w[11:9]; alu_op=ADD.
//   - M_TYPE: rd, rs1, rs2; mem_op=w[15:12]; alu_op=ADD; useAddr=1; is_double_word=1.
//     rfWrite=1 only for mem_op in {LW,LB,LHW}.
//   - SYS_END: all register fields 0.
//   - Other opcodes: all-zero bundle.
// - FSM FIRST: on in_valid&&in_ready, decode word.
//   - Single-word: push {sig, imm=0} same edge.
//   - Double-word: latch bundle into hold reg, go to SECOND (no push).
// - FSM SECOND: next accepted word is the immediate; push {held sig, imm=in_word}; return to FIRST. No decode of this word.
// - in_ready = !halted && (count < DEPTH). Combinational only from registered state; no path from out_ready.
// - Push and pop in the same cycle: count unchanged; pop-only -1; push-only +1. FIFO pointers wrap modulo DEPTH.
// - Latency: single-word instr visible at out_valid the cycle after acceptance; double-word the cycle after its imm is accepted.
// - out_sig/out_imm are held stable while out_valid && !out_ready.
// - SYS_END: pushed as a normal entry; halted=1 from next cycle; in_ready=0 until flush or reset. Queue still drains.
// - flush: highest priority over push/pop same cycle. Next cycle: queue empty, count=0, FSM=FIRST, hold reg cleared, halted=0. Concurrent in_word and pop are discarded.
// - Reset mid double-word or with full queue: all state discarded exactly as at power-up.
// CONFIGURATION
// - DECODE_ILLEGAL_TRAP_EN defined:
//   - extra port illegal (out, 1), qualified by out_valid; marks head entry as decoded from an undefined opcode.
//   - Each FIFO entry carries an illegal bit.
//   - An illegal push also sets halted, exactly as SYS_END does.
// - Not defined: no illegal port or bit; undefined opcodes push an all-zero bundle and do not halt.
// TESTING
// - Reset: hold reset_n=0 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=1 after release.
// - R_TYPE rs1=1,rs2=2,rd=3,alu_op=ADD, out_ready=1 -> next cycle out_valid=1, rfWrite=1, out_imm=0, count=1.
// - I_TYPE word, then imm 16'hBEEF with a 2-cycle in_valid gap -> nothing pushed until the imm; then useImm=1, is_double_word=1, out_imm=16'hBEEF.
// - out_ready=0, feed DEPTH R_TYPEs -> count=DEPTH, in_ready=0; then out_ready=1 with in_valid=1 -> count holds at DEPTH-1..DEPTH with no loss, and order is preserved.
// - M_TYPE LW then M_TYPE store, each with imm -> rfWrite 1 then 0; SYS_END after them -> halted=1, in_ready=0, queue drains 3 entries.
// - flush asserted in SECOND with 2 queued entries -> next cycle count=0, out_valid=0, halted=0; the next word is decoded as a fresh instruction.

Source files
------------

// File: rtl/decode_queue_unit.sv
// Decode stage: turns fetched words into decoded bundles, pairs double-word instructions with their immediate,
// and queues the results for execute. Optional macro DECODE_ILLEGAL_TRAP_EN adds an illegal-opcode flag and trap.
module decode_queue_unit #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [WORD_W-1:0]          in_word,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [40:0]                out_sig,
    output logic [WORD_W-1:0]          out_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                       illegal
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [2:0] OP_R   = 3'd0;
    localparam logic [2:0] OP_I   = 3'd1;
    localparam logic [2:0] OP_B   = 3'd2;
    localparam logic [2:0] OP_J   = 3'd3;
    localparam logic [2:0] OP_M   = 3'd4;
    localparam logic [2:0] OP_SYS = 3'd7;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] MEM_LW  = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LHW = 4'd2;

    // Field order fixes the bit layout of out_sig (opcode at the MSBs, rf_write at bit 0).
    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic [3:0] alu_op;
        logic [3:0] offset;
        logic [2:0] b_type;
        logic [8:0] addr_offset;
        logic       jump_type;
        logic [3:0] mem_op;
        logic       use_imm;
        logic       use_addr;
        logic       is_double_word;
        logic       rf_write;
    } dec_sig_t;

    typedef enum logic {S_FIRST, S_SECOND} state_t;

    function automatic dec_sig_t decode_word(input logic [15:0] w);
        dec_sig_t s;
        s = '0;
        case (w[2:0])
            OP_R: begin
                s.opcode   = OP_R;
                s.rs1      = w[5:3];
                s.rs2      = w[8:6];
                s.rd       = w[11:9];
                s.alu_op   = w[15:12];
                s.rf_write = 1'b1;
            end
            OP_I: begin
                s.opcode         = OP_I;
                s.rs1            = w[5:3];
                s.rd             = w[11:9];
                s.alu_op         = w[15:12];
                s.use_imm        = 1'b1;
                s.is_double_word = 1'b1;
                s.rf_write       = 1'b1;
            end
            OP_B: begin
                s.opcode = OP_B;
                s.rs1    = w[5:3];
                s.rs2    = w[8:6];
                s.offset = w[12:9];
                s.b_type = w[15:13];
                s.alu_op = ALU_ADD;
            end
            OP_J: begin
                s.opcode      = OP_J;
                s.addr_offset = {w[15:12], w[8:4]};
                s.jump_type   = w[6];
                s.rd          = w[11:9];
                s.alu_op      = ALU_ADD;
            end
            OP_M: begin
                s.opcode         = OP_M;
                s.rd             = w[11:9];
                s.rs1            = w[5:3];
                s.rs2            = w[8:6];
                s.mem_op         = w[15:12];
                s.alu_op         = ALU_ADD;
                s.use_addr       = 1'b1;
                s.is_double_word = 1'b1;
                s.rf_write       = (w[15:12] == MEM_LW) || (w[15:12] == MEM_LB) ||
                                   (w[15:12] == MEM_LHW);
            end
            OP_SYS: s.opcode = OP_SYS;
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t            state_q, state_d;
    dec_sig_t          hold_q, hold_d;
    logic              halted_q, halted_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    dec_sig_t          sig_mem_q [DEPTH];
    logic [WORD_W-1:0] imm_mem_q [DEPTH];

    dec_sig_t          dec;
    dec_sig_t          push_sig;
    logic [WORD_W-1:0] push_imm;
    logic              push;
    logic              pop;
    logic              accept;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              ill_mem_q [DEPTH];
    logic              dec_illegal;
    logic              push_ill;
`endif

    assign in_ready  = !halted_q && (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_sig   = out_valid ? sig_mem_q[rd_ptr_q] : '0;
    assign out_imm   = out_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign halted    = halted_q;
    assign count     = count_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal   = out_valid && ill_mem_q[rd_ptr_q];
`endif

    always_comb begin
        dec      = decode_word(in_word[15:0]);
        accept   = in_valid && in_ready;
        pop      = out_valid && out_ready;
        state_d  = state_q;
        hold_d   = hold_q;
        halted_d = halted_q;
        push     = 1'b0;
        push_sig = dec;
        push_imm = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec_illegal = !(in_word[2:0] inside {OP_R, OP_I, OP_B, OP_J, OP_M, OP_SYS});
        push_ill    = 1'b0;
`endif
        if (accept) begin
            if (state_q == S_FIRST) begin
                if (dec.is_double_word) begin
                    hold_d  = dec;
                    state_d = S_SECOND;
                end else begin
                    push = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
                    push_ill = dec_illegal;
                    if (in_word[2:0] == OP_SYS || dec_illegal) halted_d = 1'b1;
`else
                    if (in_word[2:0] == OP_SYS) halted_d = 1'b1;
`endif
                end
            end else begin
                // Second word is the raw immediate; it is never decoded.
                push     = 1'b1;
                push_sig = hold_q;
                push_imm = in_word;
                state_d  = S_FIRST;
            end
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (flush) begin
            state_d  = S_FIRST;
            hold_d   = '0;
            halted_d = 1'b0;
            push     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_FIRST;
            hold_q   <= '0;
            halted_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            halted_q <= halted_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is data only; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            sig_mem_q[wr_ptr_q] <= push_sig;
            imm_mem_q[wr_ptr_q] <= push_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_mem_q[wr_ptr_q] <= push_ill;
`endif
        end
    end

endmodule

// File: tb/tb_decode_queue_unit.sv
// Directed bench for decode_queue_unit: decode vector table plus multi-cycle sequences
// (double-word assembly, full queue, halt on SYS_END, flush mid double-word).
module tb_decode_queue_unit;

    localparam int WORD_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic [40:0]       out_sig;
    logic [WORD_W-1:0] out_imm;
    logic              out_valid;
    logic              out_ready;
    logic              halted;
    logic [CNT_W-1:0]  count;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              illegal;
`endif

    int checks = 0;
    int errors = 0;

    decode_queue_unit #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_word  (in_word),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_sig  (out_sig),
        .out_imm  (out_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .halted   (halted),
        .count    (count)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal  (illegal)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] word;
        logic [40:0] sig;
    } vec_t;

    // Packs hand-written field values into the out_sig layout.
    function automatic logic [40:0] mk(input logic [2:0] op, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic [2:0] rd,
                                       input logic [3:0] alu, input logic [3:0] off,
                                       input logic [2:0] bt, input logic [8:0] ao,
                                       input logic jt, input logic [3:0] mop,
                                       input logic ui, input logic ua,
                                       input logic dw, input logic rw);
        return {op, rs1, rs2, rd, alu, off, bt, ao, jt, mop, ui, ua, dw, rw};
    endfunction

    function automatic logic [15:0] wfull(input int i);
        logic [3:0] v;
        v = 4'(i);
        return {v, v[2:0], 3'b000, v[2:0], 3'b000};
    endfunction

    function automatic logic [40:0] efull(input int i);
        logic [3:0] v;
        v = 4'(i);
        return mk(3'd0, v[2:0], 3'd0, v[2:0], v, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    vec_t        vecs[6];
    logic [40:0] sb[$];
    logic [40:0] exp_sig;
    logic [15:0] mseq[5];
    int          idx;
    int          popped;
    int          min_cnt;

    initial begin
        vecs[0] = '{16'h0688, mk(3'd0, 3'd1, 3'd2, 3'd3, 4'd0, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[1] = '{16'h5F30, mk(3'd0, 3'd6, 3'd4, 3'd7, 4'd5, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[2] = '{16'hD55A, mk(3'd2, 3'd3, 3'd5, 3'd0, 4'd0, 4'hA, 3'd6, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[3] = '{16'h9B63, mk(3'd3, 3'd0, 3'd0, 3'd5, 4'd0, 4'd0, 3'd0, 9'h136, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[4] = '{16'hFFF8, mk(3'd0, 3'd7, 3'd7, 3'd7, 4'hF, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[5] = '{16'hFFFD, 41'd0};

        // Reset held with in_valid active must not let anything in.
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_word = 16'h0688; out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_sig", 64'(out_sig), 64'd0);
        in_valid = 1'b0;
        reset_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_halted", 64'(halted), 64'd0);
        step();
        check("rst_count_after", 64'(count), 64'd0);

        // Single-word decode table, one instruction per cycle with execute always ready.
        for (int i = 0; i < 6; i++) begin
            in_word = vecs[i].word;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_sig", i), 64'(out_sig), 64'(vecs[i].sig));
            check($sformatf("vec%0d_imm", i), 64'(out_imm), 64'd0);
            check($sformatf("vec%0d_count", i), 64'(count), 64'd1);
        end
        step();
        check("table_drained", 64'(count), 64'd0);

        // I_TYPE with a two-cycle gap before its immediate.
        in_word = 16'h3951; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("i_first_nopush", 64'(out_valid), 64'd0);
        step();
        step();
        check("i_gap_count", 64'(count), 64'd0);
        in_word = 16'hBEEF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("i_valid", 64'(out_valid), 64'd1);
        check("i_sig", 64'(out_sig),
              64'(mk(3'd1, 3'd2, 3'd0, 3'd4, 4'd3, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1)));
        check("i_imm", 64'(out_imm), 64'hBEEF);
        step();
        check("i_drained", 64'(count), 64'd0);

        // Fill the queue, then stream through it with push and pop overlapping.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_word = wfull(i); in_valid = 1'b1;
            step();
            sb.push_back(efull(i));
        end
        in_valid = 1'b0;
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        idx = DEPTH; popped = 0; min_cnt = DEPTH;
        in_word = wfull(idx); in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && popped < 8; cyc++) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("stream_sb_underflow", 64'(out_sig), 64'd0);
                    exp_sig = '0;
                end else begin
                    exp_sig = sb.pop_front();
                end
                check($sformatf("stream_head%0d", popped), 64'(out_sig), 64'(exp_sig));
                popped++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(efull(idx));
                idx++;
            end
            step();
            if (idx < 8) begin
                if (int'(count) < min_cnt) min_cnt = int'(count);
                in_word = wfull(idx);
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream_popped", 64'(popped), 64'd8);
        check("stream_min_count", 64'(min_cnt >= DEPTH - 1), 64'd1);
        check("stream_end_count", 64'(count), 64'd0);

        // M_TYPE load, M_TYPE store, then SYS_END; execute stalled.
        mseq[0] = 16'h04CC; mseq[1] = 16'h1234; mseq[2] = 16'h31AC; mseq[3] = 16'h00AB; mseq[4] = 16'hABC7;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_word = mseq[i]; in_valid = 1'b1;
            step();
        end
        check("sys_halted", 64'(halted), 64'd1);
        check("sys_in_ready", 64'(in_ready), 64'd0);
        check("sys_count", 64'(count), 64'd3);
        in_word = 16'h0688;
        step();
        check("sys_closed_count", 64'(count), 64'd3);
        check("m_lw_sig", 64'(out_sig),
              64'(mk(3'd4, 3'd1, 3'd3, 3'd2, 4'd0, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1)));
        check("m_lw_imm", 64'(out_imm), 64'h1234);
        out_ready = 1'b1;
        step();
        check("m_sw_sig", 64'(out_sig),
              64'(mk(3'd4, 3'd5, 3'd6, 3'd0, 4'd0, 4'd0, 3'd0, 9'd0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0)));
        check("m_sw_imm", 64'(out_imm), 64'h00AB);
        step();
        check("sys_sig", 64'(out_sig),
              64'(mk(3'd7, 3'd0, 3'd0, 3'd0, 4'd0, 4'd0, 3'd0, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        check("sys_imm", 64'(out_imm), 64'd0);
        step();
        in_valid = 1'b0;
        check("sys_drained", 64'(count), 64'd0);
        check("sys_still_halted", 64'(halted), 64'd1);

        // Flush clears the halt; then flush again while mid double-word with two queued entries.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_unhalt", 64'(halted), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        in_word = 16'h5F30; in_valid = 1'b1;
        step();
        in_word = 16'hFFF8;
        step();
        in_word = 16'h3951;
        step();
        check("pre_flush_count", 64'(count), 64'd2);
        flush = 1'b1; in_word = 16'hBEEF; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_halted", 64'(halted), 64'd0);
        in_word = 16'h0688; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_flush_sig", 64'(out_sig), 64'(vecs[0].sig));
        check("post_flush_imm", 64'(out_imm), 64'd0);
        check("post_flush_count", 64'(count), 64'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
